uart_tx_periph: RTL and testbench
=================================

// Module: uart_tx_periph
// PURPOSE
// - Memory-mapped UART transmitter on the RV32I core's data bus, downstream of the core's load/store port.
// - Core stores bytes into an 8-deep TX FIFO; an FSM serialises them 8N1, LSB first, on tx.
// - Status and baud divisor are readable via dataRData, combinationally, for the single-cycle load path.
// PARAMETERS
// - FIFO_DEPTH   8     TX FIFO entries; power of 2, >= 2
// - DEFAULT_DIV  867   BAUDDIV reset value; bit period = BAUDDIV+1 clk (100 MHz -> 115200 baud)
// - DIV_W        16    BAUDDIV register width
// PORTS
// - clk        in   1    system clock, rising edge
// - reset      in   1    synchronous, active-high
// - sel        in   1    address decoder hit for this peripheral
// - dataWe     in   1    store strobe, qualified by sel
// - dataAddr   in   4    byte offset within peripheral; [1:0] ignored
// - dataWData  in   32   store data
// - dataRData  out  32   load data, combinational; 0 when sel=0
// - tx         out  1    serial line, idle high, registered
// BEHAVIOUR
// - Register map:
//   - 0x0 TXDATA:  write pushes dataWData[7:0]; reads 0.
//   - 0x4 STATUS:  [0] full, [1] empty, [2] busy, [3] overflow (sticky), [15:8] FIFO count.
//     Write 1 to bit 3 clears overflow; other bits read-only.
//   - 0x8 BAUDDIV: [DIV_W-1:0], read/write. Value is latched at frame start, so it takes effect from the next frame.
//   - 0xC and all unused bits: read 0, writes ignored.
// - Reset values: tx=1, FIFO empty, count=0, overflow=0, BAUDDIV=DEFAULT_DIV, FSM=IDLE, busy=0.
// - Write commits on the clk edge where sel & dataWe.
// - Push to a full FIFO:
//   - Dropped and overflow set, unless a pop occurs in the same cycle; then it is accepted and count is unchanged.
// - FSM states:
//   - IDLE:
//     - tx=1.
//     - If FIFO non-empty: pop head into shifter, latch BAUDDIV, go to START.
//   - START: tx=0 for BAUDDIV+1 cycles -> DATA.
//   - DATA:
//     - Shifts out 8 bits LSB first, BAUDDIV+1 cycles each; bit counter 0..7.
//     - After bit 7 -> PARITY if enabled, else STOP.
//   - PARITY (UART_TX_PARITY_EN only): tx = ^byte (even parity), one bit period -> STOP.
//   - STOP:
//     - tx=1 for one bit period -> IDLE.
//     - Next byte starts the cycle after STOP ends, so consecutive frames have no extra idle cycle beyond the IDLE pop.
// - Latency: write at edge N to an empty FIFO with FSM idle -> pop at edge N+1 -> tx=0 from edge N+2.
// - busy = (state != IDLE).
// - Baud counter:
//   - Counts 0..latched_div, then wraps at the bit boundary.
//   - BAUDDIV=0 gives a 1-cycle bit period (legal).
// - FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.
// - Count is a separate log2(FIFO_DEPTH)+1 bit counter.
// - Reset mid-frame: tx=1 on the next edge, frame aborted, FIFO flushed, BAUDDIV restored.
// CONFIGURATION
// - UART_TX_PARITY_EN defined:
//   - PARITY state present; frame is 8E1 (11 bit periods).
//   - STATUS[4] reads 1 (parity present).
// - UART_TX_PARITY_EN undefined:
//   - 8N1 frame (10 bit periods); STATUS[4] reads 0.
//   - No parity logic synthesised.
// TESTING
// - Reset:
//   - Assert reset 2 cycles -> tx=1.
//   - Read 0x4 = 0x0000_0002 (0x0000_0012 with parity).
//   - Read 0x8 = 867.
// - Single byte, 8N1:
//   - Write 0x8=3, then 0x0=0x55 -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles.
//   - 40 cycles total from edge N+2; busy=0 afterwards.
// - Overflow:
//   - BAUDDIV=100; write 10 bytes back-to-back -> first popped, count=8, full=1, overflow=1, 10th byte never sent.
//   - Write 0x4=0x8 -> overflow=0.
// - Back-to-back:
//   - BAUDDIV=1; write 0xA5, 0x3C -> two complete frames.
//   - Second start bit begins 1 cycle after the first stop bit ends (IDLE pop); bytes arrive in order.
// - Reset mid-frame:
//   - Assert reset during DATA bit 3 -> next edge tx=1, count=0, busy=0.
//   - No further transitions on tx.
// - Parity (UART_TX_PARITY_EN):
//   - BAUDDIV=0; write 0x07 -> frame 0,1,1,1,0,0,0,0,0,1(parity),1(stop).
//   - Write 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped UART transmitter for the RV32I data bus.
// Stores to TXDATA fill an 8-deep FIFO; an FSM drains it onto tx as 8N1 frames, LSB first.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (8E1) and sets STATUS[4].
//
// Register map (dataAddr[3:2]):
//   0x0 TXDATA   write pushes dataWData[7:0]; reads 0
//   0x4 STATUS   [0] full [1] empty [2] busy [3] overflow (W1C) [4] parity present [15:8] count
//   0x8 BAUDDIV  bit period = BAUDDIV+1 clk; latched at frame start
//   0xC          reads 0, writes ignored

module uart_tx_periph #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DEFAULT_DIV = 867,
    parameter int unsigned DIV_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        dataWe,
    input  logic [3:0]  dataAddr,
    input  logic [31:0] dataWData,
    output logic [31:0] dataRData,
    output logic        tx
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [1:0] AddrTxData  = 2'd0;
    localparam logic [1:0] AddrStatus  = 2'd1;
    localparam logic [1:0] AddrBaudDiv = 2'd2;

`ifdef UART_TX_PARITY_EN
    localparam logic ParPresent = 1'b1;
`else
    localparam logic ParPresent = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
`ifdef UART_TX_PARITY_EN
        , StParity
`endif
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;

    // Control registers
    logic             ovf_q, ovf_d;
    logic [DIV_W-1:0] div_q, div_d;

    // Transmitter
    state_e           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic [2:0]       bit_q, bit_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [DIV_W-1:0] divl_q, divl_d;
    logic             tx_q, tx_d;

    logic       wr_hit;
    logic [1:0] reg_sel;
    logic       push_req;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic       busy;
    logic       tick;

    // Address bits [1:0] and most of the store data have no function here.
    logic unused_bits;
    assign unused_bits = ^{dataAddr[1:0], dataWData};

    assign wr_hit   = sel & dataWe;
    assign reg_sel  = dataAddr[3:2];
    assign push_req = wr_hit && (reg_sel == AddrTxData);
    assign full     = (fifo_cnt_q == CntW'(FIFO_DEPTH));
    assign empty    = (fifo_cnt_q == '0);
    assign busy     = (state_q != StIdle);
    assign pop      = (state_q == StIdle) && !empty;
    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);
    assign tick     = (baud_q == divl_q);
    assign tx       = tx_q;

    // FIFO next state: write at wptr, read at rptr, separate occupancy counter
    always_comb begin
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            mem_d[wptr_q] = dataWData[7:0];
            wptr_d        = wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Control register next state: sticky overflow with write-1-to-clear, baud divisor
    always_comb begin
        ovf_d = ovf_q;
        div_d = div_q;
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end else if (wr_hit && (reg_sel == AddrStatus) && dataWData[3]) begin
            ovf_d = 1'b0;
        end
        if (wr_hit && (reg_sel == AddrBaudDiv)) begin
            div_d = dataWData[DIV_W-1:0];
        end
    end

    // Transmit FSM next state; tx_d is registered so the line is glitch-free
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        divl_d  = divl_q;
        tx_d    = 1'b1;
        if (state_q != StIdle) begin
            baud_d = tick ? '0 : baud_q + DIV_W'(1);
        end
        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!empty) begin
                    byte_d  = mem_q[rptr_q];
                    divl_d  = div_q;
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                tx_d = 1'b0;
                if (tick) begin
                    bit_d   = 3'd0;
                    state_d = StData;
                end
            end
            StData: begin
                tx_d = byte_q[bit_q];
                if (tick) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                tx_d = ^byte_q;
                if (tick) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                tx_d = 1'b1;
                if (tick) begin
                    state_d = StIdle;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    // Load data mux, combinational for the single-cycle load path
    always_comb begin
        dataRData = '0;
        if (sel) begin
            case (reg_sel)
                AddrTxData:  dataRData = '0;
                AddrStatus:  dataRData = {16'b0, 8'(fifo_cnt_q), 3'b0, ParPresent, ovf_q, busy,
                                          empty, full};
                AddrBaudDiv: dataRData = 32'(div_q);
                default:     dataRData = '0;
            endcase
        end
    end

    // FIFO payload storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control and transmitter state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            fifo_cnt_q <= '0;
            ovf_q      <= 1'b0;
            div_q      <= DIV_W'(DEFAULT_DIV);
            state_q    <= StIdle;
            byte_q     <= '0;
            bit_q      <= '0;
            baud_q     <= '0;
            divl_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            ovf_q      <= ovf_d;
            div_q      <= div_d;
            state_q    <= state_d;
            byte_q     <= byte_d;
            bit_q      <= bit_d;
            baud_q     <= baud_d;
            divl_q     <= divl_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph. A monitor records tx once per cycle; expected line
// waveforms are built from frame rules (start, data LSB first, optional parity, stop).
module tb_uart_tx_periph;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        dataWe;
    logic [3:0]  dataAddr;
    logic [31:0] dataWData;
    logic [31:0] dataRData;
    logic        tx;

    int tests = 0;
    int fails = 0;
    int edge_no = 0;
    logic hist [0:32767];
    bit   exp_q[$];

`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] ParFlag = 32'h10;
`else
    localparam logic [31:0] ParFlag = 32'h0;
`endif

    always #5 clk = ~clk;

    uart_tx_periph dut (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .dataWe    (dataWe),
        .dataAddr  (dataAddr),
        .dataWData (dataWData),
        .dataRData (dataRData),
        .tx        (tx)
    );

    // Record tx 1 ns after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            edge_no++;
            #1;
            if (edge_no < 32768) hist[edge_no] = tx;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Store; n returns the edge number at which the store committed.
    task automatic wr(input logic [3:0] a, input logic [31:0] d, output int n);
        @(negedge clk);
        sel = 1'b1; dataWe = 1'b1; dataAddr = a; dataWData = d;
        @(posedge clk);
        #1;
        n = edge_no;
        sel = 1'b0; dataWe = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; dataWe = 1'b0; dataAddr = a;
        #1;
        d = dataRData;
        sel = 1'b0;
    endtask

    // Append one frame to exp_q; frames after the first are preceded by the one idle pop cycle.
    task automatic add_frame(input logic [7:0] b, input int div, input bit first);
        bit bits[$];
        if (!first) exp_q.push_back(1'b1);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[k]) repeat (div + 1) exp_q.push_back(bits[k]);
    endtask

    // Compare the recorded line from edge n0+2 onward against exp_q plus two idle cycles.
    task automatic check_stream(input string tag, input int n0);
        int target;
        int bad;
        int first_bad;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        target = n0 + 2 + exp_q.size();
        while (edge_no < target) @(posedge clk);
        #2;
        bad = 0;
        first_bad = -1;
        foreach (exp_q[i]) begin
            if (hist[n0 + 2 + i] !== exp_q[i]) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        tests++;
        assert (bad == 0) else begin
            fails++;
            $error("FAIL %s: %0d wrong tx cycles, first at offset %0d got %b expected %b",
                   tag, bad, first_bad, hist[n0 + 2 + first_bad], exp_q[first_bad]);
        end
        exp_q.delete();
    endtask

    initial begin
        int          n0;
        int          n1;
        int          nd;
        int          div;
        int          k;
        logic [31:0] r;
        logic [7:0]  b;
        logic [7:0]  bq[$];

        reset = 1'b1; sel = 1'b0; dataWe = 1'b0; dataAddr = '0; dataWData = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tx", {31'b0, tx}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        rd(4'h4, r); chk("reset_status", r, 32'h2 | ParFlag);
        rd(4'h8, r); chk("reset_baud", r, 32'd867);
        rd(4'h0, r); chk("txdata_reads0", r, 32'd0);
        rd(4'hC, r); chk("addrC_reads0", r, 32'd0);
        @(negedge clk);
        dataAddr = 4'h8; sel = 1'b0;
        #1;
        chk("unselected_reads0", dataRData, 32'd0);

        // Divisor write, readback, and ignored writes to 0xC / upper bits.
        wr(4'h8, 32'hFFFF_0003, nd);
        rd(4'h8, r); chk("baud_write", r, 32'd3);
        wr(4'hC, 32'hFFFF_FFFF, nd);
        rd(4'h8, r); chk("addrC_ignored_baud", r, 32'd3);
        rd(4'h4, r); chk("addrC_ignored_status", r, 32'h2 | ParFlag);

        // Single byte at BAUDDIV=3.
        wr(4'h0, 32'h55, n0);
        add_frame(8'h55, 3, 1'b1);
        check_stream("single_0x55", n0);
        rd(4'h4, r); chk("single_idle_status", r, 32'h2 | ParFlag);

        // Back-to-back frames at BAUDDIV=1.
        wr(4'h8, 32'd1, nd);
        wr(4'h0, 32'hA5, n0);
        wr(4'h0, 32'h3C, nd);
        add_frame(8'hA5, 1, 1'b1);
        add_frame(8'h3C, 1, 1'b0);
        check_stream("back_to_back", n0);

        // BAUDDIV=0 single-cycle bit periods; covers the parity bit when enabled.
        wr(4'h8, 32'd0, nd);
        wr(4'h0, 32'h07, n0);
        add_frame(8'h07, 0, 1'b1);
        check_stream("div0_0x07", n0);
        wr(4'h0, 32'h03, n0);
        add_frame(8'h03, 0, 1'b1);
        check_stream("div0_0x03", n0);

        // Randomised frames with random divisor and burst length.
        for (int it = 0; it < 4; it++) begin
            div = $urandom_range(0, 4);
            k = $urandom_range(1, 3);
            bq.delete();
            wr(4'h8, div, nd);
            for (int j = 0; j < k; j++) begin
                b = 8'($urandom);
                bq.push_back(b);
                wr(4'h0, {24'b0, b}, nd);
                if (j == 0) n0 = nd;
            end
            // First byte leaves the FIFO on the edge after its store.
            rd(4'h4, r);
            chk($sformatf("rand%0d_count", it), (r >> 8) & 32'hFF, (k >= 2) ? k - 1 : k);
            foreach (bq[j]) add_frame(bq[j], div, j == 0);
            check_stream($sformatf("rand%0d_stream", it), n0);
        end

        // Overflow: 10 stores at BAUDDIV=100; one popped, eight queued, tenth dropped.
        wr(4'h8, 32'd100, nd);
        bq.delete();
        for (int j = 0; j < 10; j++) begin
            b = 8'($urandom);
            bq.push_back(b);
            wr(4'h0, {24'b0, b}, nd);
            if (j == 0) n0 = nd;
        end
        rd(4'h4, r); chk("ovf_status", r, 32'h080D | ParFlag);
        wr(4'h4, 32'h8, nd);
        rd(4'h4, r); chk("ovf_cleared", r, 32'h0805 | ParFlag);
        for (int j = 0; j < 9; j++) add_frame(bq[j], 100, j == 0);
        check_stream("ovf_nine_frames", n0);
        rd(4'h4, r); chk("ovf_drained", r, 32'h2 | ParFlag);

        // Reset during data bit 3 of an all-zero byte with a second byte queued.
        wr(4'h8, 32'd3, nd);
        wr(4'h0, 32'h00, n0);
        wr(4'h0, 32'h00, nd);
        while (edge_no < n0 + 18) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midframe_tx_low_before", {31'b0, hist[n0 + 18]}, 32'd0);
        chk("midframe_tx_after_reset", {31'b0, tx}, 32'd1);
        rd(4'h4, r); chk("midframe_status", r, 32'h2 | ParFlag);
        rd(4'h8, r); chk("midframe_baud", r, 32'd867);
        @(negedge clk);
        reset = 1'b0;
        n1 = edge_no;
        repeat (60) exp_q.push_back(1'b1);
        check_stream("midframe_quiet", n1 - 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
